mc_control_fsm: RTL

- Main multicycle control unit of the MIPS core.
- Decodes Opcode and sequences the datapath through fetch/decode/execute/memory/writeback states.
- Drives the 3-bit ALUOp consumed by the ALU control stage directly downstream.
- Consumes that stage's Break flag, plus the ALU Zero and Overflow flags.

---
 rtl/mc_control_fsm.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm -- main multicycle control unit of the MIPS core.
//
// Decodes Opcode and steps the datapath through fetch / decode / execute /
// memory / writeback. FETCH, MEM_RD and MEM_WR each last MEM_LAT cycles.
// All outputs are Moore-decoded from the state register. The only exception
// is PCWrite in BRANCH, which also depends on Zero.
//
// Optional feature macro: OVF_TRAP_EN
//   defined   : signed add/sub/addi overflow diverts to EXCEPT (EPC load,
//               PC <- ExcAddr). The register write is skipped.
//   undefined : Overflow is ignored, EXCEPT is unreachable, EPCWrite = 0.
//
// Ports
//   clk, reset_n         clock (rising edge), async active-low reset
//   Opcode, Funct        IR[31:26], IR[5:0]
//   Break                from ALU control, 1 when Funct == 6'h0d
//   Zero, Overflow       ALU flags
//   ALUOp                000 add, 001 sub, 010 by Funct, 011 xor, 100 and
//   ALUSrcA/ALUSrcB      ALU operand selects
//   IorD                 memory address select
//   MemRead/MemWrite     memory strobes
//   IRWrite/RegWrite     instruction register and register file writes
//   RegDst/MemToReg      register file write selects
//   PCWrite/PCSource     PC load and PC source select
//   EPCWrite, ExcAddr    exception PC load and exception vector
//   Halted, State        break indication and debug state encoding
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Break,
  input  logic        Zero,
  input  logic        Overflow,
  output logic [2:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic        EPCWrite,
  output logic [31:0] ExcAddr,
  output logic        Halted,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_WB  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_HALT     = 4'd12,
    S_EXCEPT   = 4'd13,
    S_IDLE     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_cycle;
  logic       counting;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_cycle = (cnt_q == LAST_CNT);
  assign counting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);

`ifdef OVF_TRAP_EN
  logic r_trap, imm_trap;
  // Only the signed add/sub forms trap. ADDU/SUBU never do.
  assign r_trap   = Overflow && ((Funct == 6'h20) || (Funct == 6'h22));
  assign imm_trap = Overflow && (Opcode == OP_ADDI);
`else
  logic unused_inputs;
  assign unused_inputs = ^{Funct, Overflow};
`endif

  // Next-state logic and latency counter.
  always_comb begin
    // NOTE: defaults come first so every path assigns every signal, which
    // keeps this block free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (last_cycle) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Opcode)
          OP_RTYPE:                 state_d = Break ? S_HALT : S_R_EXEC;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_XORI: state_d = S_IMM_EXEC;
          default:                  state_d = S_FETCH;   // unknown opcode: nop
        endcase
      end
      S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (last_cycle) state_d = S_LOAD_WB;
      S_MEM_WR:   if (last_cycle) state_d = S_FETCH;
`ifdef OVF_TRAP_EN
      S_R_EXEC:   state_d = r_trap ? S_EXCEPT : S_R_WB;
      S_IMM_EXEC: state_d = imm_trap ? S_EXCEPT : S_IMM_WB;
`else
      S_R_EXEC:   state_d = S_R_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
`endif
      S_HALT:     state_d = S_HALT;                     // sticky until reset
      default:    state_d = S_FETCH;                    // all writeback/branch/jump/except
    endcase

    // The counter restarts on every state change, so it reads 0 on the first
    // cycle of any multi-cycle state.
    cnt_d = '0;
    if ((state_d == state_q) && counting) cnt_d = cnt_q + 4'd1;
  end

  // Moore output decode.
  always_comb begin
    ALUOp    = 3'b000;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 2'b00;
    EPCWrite = 1'b0;
    Halted   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = last_cycle;   // single-shot loads on the final memory cycle
        PCWrite = last_cycle;
      end
      S_DECODE:   ALUSrcB = 2'b11;                   // branch target into ALUOut
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LOAD_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        PCWrite  = (Opcode == OP_BEQ) ? Zero : !Zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Opcode == OP_ANDI)      ALUOp = 3'b100;
        else if (Opcode == OP_XORI) ALUOp = 3'b011;
      end
      S_IMM_WB:   RegWrite = 1'b1;
      S_HALT:     Halted = 1'b1;
`ifdef OVF_TRAP_EN
      S_EXCEPT: begin
        EPCWrite = 1'b1;
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
`endif
      default: ;                                     // IDLE: all strobes low
    endcase
  end

  assign ExcAddr = EXC_VECTOR;
  assign State   = state_q;

endmodule
